// File: rtl/i2c_pkg.sv
// Command encodings and sequencer state codes shared by the I2C EEPROM
// sequencer and i2c_interface.
package i2c_pkg;

  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_WR    = 4'b0010;
  localparam logic [3:0] CMD_RD    = 4'b0100;
  localparam logic [3:0] CMD_STOP  = 4'b1000;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_WR_CTRL  = 4'd1;
  localparam state_t S_WR_ADDR  = 4'd2;
  localparam state_t S_WR_DATA  = 4'd3;
  localparam state_t S_WR_WAIT  = 4'd4;
  localparam state_t S_RD_CTRL  = 4'd5;
  localparam state_t S_RD_ADDR  = 4'd6;
  localparam state_t S_RD_CTRLR = 4'd7;
  localparam state_t S_RD_DATA  = 4'd8;
  localparam state_t S_ABORT    = 4'd9;
  localparam state_t S_DONE     = 4'd10;

  // Command issued to i2c_interface in each byte-phase state; 0 marks a non-byte state.
  function automatic logic [3:0] step_cmd(input state_t s);
    case (s)
      S_WR_CTRL, S_RD_CTRL, S_RD_CTRLR: step_cmd = CMD_START | CMD_WR;
      S_WR_ADDR, S_RD_ADDR:             step_cmd = CMD_WR;
      S_WR_DATA:                        step_cmd = CMD_STOP | CMD_WR;
      S_RD_DATA:                        step_cmd = CMD_STOP | CMD_RD;
      S_ABORT:                          step_cmd = CMD_STOP;
      default:                          step_cmd = 4'b0000;
    endcase
  endfunction

  function automatic logic is_step(input state_t s);
    return step_cmd(s) != 4'b0000;
  endfunction

endpackage

// File: rtl/i2c_eeprom_ctrl.sv
// Byte-write / random-read EEPROM transaction sequencer driving i2c_interface.
// Handles slave NACK with a STOP-only abort and the post-write tWR idle period.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | rdy=1, waiting for wr_req / rd_req
// S_WR_CTRL  | send START + control byte (write)
// S_WR_ADDR  | send word address
// S_WR_DATA  | send data byte + STOP
// S_WR_WAIT  | idle WR_WAIT_CYC cycles for the EEPROM internal write
// S_RD_CTRL  | send START + control byte (write, sets address pointer)
// S_RD_ADDR  | send word address
// S_RD_CTRLR | repeated START + control byte (read)
// S_RD_DATA  | receive one byte, master NACK + STOP
// S_ABORT    | STOP only, after a slave NACK
// S_DONE     | one-cycle completion pulse
module i2c_eeprom_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'b1010000,
  parameter int         WR_WAIT_CYC = 250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       rdy,
  output logic       done,
  output logic       err,
  output logic [7:0] rd_data,
  output logic       rd_vld,
  output logic       req,
  output logic [3:0] cmd,
  output logic [7:0] wr_din,
  input  logic       rw_done,
  input  logic       wr_fail,
  input  logic [7:0] rd_dout
);

  localparam int CW = (WR_WAIT_CYC > 0) ? $clog2(WR_WAIT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((WR_WAIT_CYC > 0) ? WR_WAIT_CYC - 1 : 0);

  state_t        state, state_n;
  logic          waiting, waiting_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_q, err_n;
  logic          rok_q, rok_n;
  logic          rdy_q;
  logic [7:0]    addr_q, wdata_q;

  always_comb begin
    state_n   = state;
    waiting_n = waiting;
    cnt_n     = cnt;
    err_n     = err_q;
    rok_n     = rok_q;
    case (state)
      S_IDLE: begin
        err_n     = 1'b0;
        rok_n     = 1'b0;
        cnt_n     = '0;
        waiting_n = 1'b0;
        if (rdy_q && wr_req)      state_n = S_WR_CTRL;
        else if (rdy_q && rd_req) state_n = S_RD_CTRL;
      end
      S_WR_WAIT: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: state_n = S_IDLE;
      default: begin
        if (!is_step(state)) begin
          state_n = S_IDLE;
        end else if (!waiting) begin
          waiting_n = 1'b1;
        end else if (rw_done) begin
          waiting_n = 1'b0;
          case (state)
            S_WR_CTRL:  state_n = wr_fail ? S_ABORT : S_WR_ADDR;
            S_WR_ADDR:  state_n = wr_fail ? S_ABORT : S_WR_DATA;
            S_WR_DATA: begin
              // STOP already went out with the data byte, so a NACK here ends directly
              err_n   = wr_fail;
              state_n = (wr_fail || WR_WAIT_CYC == 0) ? S_DONE : S_WR_WAIT;
            end
            S_RD_CTRL:  state_n = wr_fail ? S_ABORT : S_RD_ADDR;
            S_RD_ADDR:  state_n = wr_fail ? S_ABORT : S_RD_CTRLR;
            S_RD_CTRLR: state_n = wr_fail ? S_ABORT : S_RD_DATA;
            S_RD_DATA: begin
              rok_n   = 1'b1;
              state_n = S_DONE;
            end
            S_ABORT: begin
              err_n   = 1'b1;
              state_n = S_DONE;
            end
            default:    state_n = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      waiting <= 1'b0;
      cnt     <= '0;
      err_q   <= 1'b0;
      rok_q   <= 1'b0;
      rdy_q   <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rd_data <= 8'h00;
    end else begin
      state   <= state_n;
      waiting <= waiting_n;
      cnt     <= cnt_n;
      err_q   <= err_n;
      rok_q   <= rok_n;
      rdy_q   <= (state_n == S_IDLE);
      if (rdy_q && (wr_req || rd_req)) begin
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state == S_RD_DATA && waiting && rw_done) rd_data <= rd_dout;
    end
  end

  always_comb begin
    case (state)
      S_WR_CTRL, S_RD_CTRL: wr_din = {DEV_ADDR, 1'b0};
      S_RD_CTRLR:           wr_din = {DEV_ADDR, 1'b1};
      S_WR_ADDR, S_RD_ADDR: wr_din = addr_q;
      S_WR_DATA:            wr_din = wdata_q;
      default:              wr_din = 8'h00;
    endcase
  end

  assign req    = is_step(state) && !waiting;
  assign cmd    = step_cmd(state);
  assign rdy    = rdy_q;
  assign done   = (state == S_DONE);
  assign err    = done && err_q;
  assign rd_vld = done && rok_q;

endmodule

// File: tb/tb_i2c_eeprom_ctrl.sv
// Bench for i2c_eeprom_ctrl: behavioural i2c_interface/EEPROM responder plus
// a request-level reference model of memory contents and returned read data.
module tb_i2c_eeprom_ctrl;

  localparam int         WAIT_CYC = 4;
  localparam logic [6:0] DEV      = 7'b1010000;
  localparam int         NONE     = 9;

  logic       clk = 1'b0, rst = 1'b1;
  logic       wr_req = 1'b0, rd_req = 1'b0, rw_done = 1'b0, wr_fail = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00, rd_dout = 8'h00;
  logic       rdy, done, err, rd_vld, req;
  logic [7:0] rd_data, wr_din;
  logic [3:0] cmd;

  int total = 0, bad = 0;

  logic [7:0] ref_mem [256];
  logic [7:0] slv_mem [256];
  logic [7:0] slv_ptr = 8'h00;
  logic [7:0] ref_rd  = 8'h00;

  typedef struct {
    logic       is_wr;
    logic [7:0] a;
    logic [7:0] d;
    int         nack_at;
    logic       exp_err;
    logic       exp_vld;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  i2c_eeprom_ctrl #(.DEV_ADDR(DEV), .WR_WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .addr(addr), .wdata(wdata),
    .rdy(rdy), .done(done), .err(err), .rd_data(rd_data), .rd_vld(rd_vld),
    .req(req), .cmd(cmd), .wr_din(wr_din),
    .rw_done(rw_done), .wr_fail(wr_fail), .rd_dout(rd_dout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, 32'(rdy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rd_vld"}, 32'(rd_vld), 0);
    chk({tag, "_req"}, 32'(req), 0);
    chk({tag, "_cmd"}, 32'(cmd), 0);
    chk({tag, "_wr_din"}, 32'(wr_din), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
  endtask

  // One user transaction, with the responder acting as i2c_interface + EEPROM.
  task automatic run_txn(input logic is_wr, input logic [7:0] a, input logic [7:0] d,
                         input int nack_at, input logic exp_err, input logic exp_vld,
                         input logic both, input logic poke, input int rst_step);
    logic [3:0] ecmd[$];
    logic [7:0] edin[$];
    logic       fail;
    int         wait_n;
    if (is_wr) begin
      ecmd = '{4'b0011, 4'b0010, 4'b1010};
      edin = '{{DEV, 1'b0}, a, d};
    end else begin
      ecmd = '{4'b0011, 4'b0010, 4'b0011, 4'b1100};
      edin = '{{DEV, 1'b0}, a, {DEV, 1'b1}, 8'h00};
    end
    // A NACK on a byte without STOP truncates the sequence and adds a STOP-only step.
    if (nack_at < 3 && !(is_wr && nack_at == 2)) begin
      while (ecmd.size() > nack_at + 1) begin
        void'(ecmd.pop_back());
        void'(edin.pop_back());
      end
      ecmd.push_back(4'b1000);
      edin.push_back(8'h00);
    end
    wait_n = (is_wr && nack_at >= 3) ? WAIT_CYC : 0;

    chk("rdy_before_req", 32'(rdy), 1);
    addr   = a;
    wdata  = d;
    wr_req = is_wr | both;
    rd_req = ~is_wr | both;
    tick;
    wr_req = 1'b0;
    rd_req = 1'b0;
    addr   = 8'($urandom);
    wdata  = 8'($urandom);
    chk("rdy_after_accept", 32'(rdy), 0);

    for (int i = 0; i < ecmd.size(); i++) begin
      chk($sformatf("step%0d_req", i), 32'(req), 1);
      chk($sformatf("step%0d_cmd", i), 32'(cmd), 32'(ecmd[i]));
      chk($sformatf("step%0d_din", i), 32'(wr_din), 32'(edin[i]));
      tick;
      chk($sformatf("step%0d_req_low", i), 32'(req), 0);
      if (i == rst_step) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("midrst");
        rst = 1'b0;
        ref_rd = 8'h00;
        tick;
        chk("midrst_rdy_after", 32'(rdy), 1);
        return;
      end
      if (poke && i == 0) begin
        rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
      end
      repeat ($urandom_range(0, 3)) tick;
      chk($sformatf("step%0d_cmd_held", i), 32'(cmd), 32'(ecmd[i]));
      chk($sformatf("step%0d_din_held", i), 32'(wr_din), 32'(edin[i]));
      fail = (i == nack_at);
      if (cmd == 4'b0010 && !fail) slv_ptr = wr_din;
      if (cmd == 4'b1010 && !fail) slv_mem[slv_ptr] = wr_din;
      rd_dout = (cmd == 4'b1100) ? slv_mem[slv_ptr] : 8'($urandom);
      rw_done = 1'b1;
      wr_fail = fail;
      tick;
      rw_done = 1'b0;
      wr_fail = 1'b0;
      rd_dout = 8'($urandom);
    end

    for (int w = 0; w < wait_n; w++) begin
      chk("wait_done_low", 32'(done), 0);
      chk("wait_rdy_low", 32'(rdy), 0);
      chk("wait_req_low", 32'(req), 0);
      tick;
    end

    if (is_wr && !exp_err) ref_mem[a] = d;
    if (exp_vld) ref_rd = ref_mem[a];
    chk("done", 32'(done), 1);
    chk("err", 32'(err), 32'(exp_err));
    chk("rd_vld", 32'(rd_vld), 32'(exp_vld));
    chk("rd_data", 32'(rd_data), 32'(ref_rd));
    tick;
    chk("done_pulse_end", 32'(done), 0);
    chk("rd_vld_end", 32'(rd_vld), 0);
    chk("rdy_after_done", 32'(rdy), 1);
    if (both || poke) begin
      for (int q = 0; q < 5; q++) begin
        chk("no_extra_txn", 32'(req), 0);
        tick;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i * 7 + 3);
      slv_mem[i] = 8'(i * 7 + 3);
    end

    vecs[0] = '{1'b1, 8'h3D, 8'hBE, NONE, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h3D, 8'h00, NONE, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h10, 8'h55, 0,    1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h3D, 8'h00, 1,    1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h3D, 8'h00, 2,    1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h3D, 8'h11, 2,    1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h3D, 8'h00, 3,    1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'hFF, 8'h00, 1,    1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 8'h00, NONE, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    tick;
    chk("rdy_after_reset", 32'(rdy), 1);

    // stray rw_done while idle must not disturb anything
    rw_done = 1'b1;
    wr_fail = 1'b1;
    tick;
    rw_done = 1'b0;
    wr_fail = 1'b0;
    chk("idle_rw_done_rdy", 32'(rdy), 1);
    chk("idle_rw_done_req", 32'(req), 0);
    chk("idle_rw_done_done", 32'(done), 0);

    for (int k = 0; k < 9; k++)
      run_txn(vecs[k].is_wr, vecs[k].a, vecs[k].d, vecs[k].nack_at,
              vecs[k].exp_err, vecs[k].exp_vld, 1'b0, 1'b0, -1);

    // simultaneous wr_req + rd_req: write wins, read dropped
    run_txn(1'b1, 8'h10, 8'hC3, NONE, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    run_txn(1'b0, 8'h10, 8'h00, NONE, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    // rd_req while busy is not queued
    run_txn(1'b1, 8'h22, 8'h9A, NONE, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    // reset during the RD_ADDR wait, then a fresh write/read
    run_txn(1'b0, 8'h3D, 8'h00, NONE, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    run_txn(1'b1, 8'h44, 8'h7E, NONE, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_txn(1'b0, 8'h44, 8'h00, NONE, 1'b0, 1'b1, 1'b0, 1'b0, -1);

    for (int r = 0; r < 40; r++) begin
      logic       w;
      logic [7:0] a, d;
      int         n;
      logic       e;
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : NONE;
      e = (n < 3);
      run_txn(w, a, d, n, e, ~w & ~e, 1'b0, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
